// File: rtl/kasumi_csr_pkg.sv
// Shared CSR addresses, mstatus field positions and the trap sequencer state enum.
package kasumi_csr_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, R_STATUS, REDIR
  } trap_state_e;

  // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction
endpackage

// File: rtl/trap_target.sv
// Combinational redirect target: mtvec base for traps, mepc for mret.
// Define TRAP_VECTORED_EN to add vectored-interrupt offsets (mtvec mode 01).
module trap_target (
  input  logic        is_mret,
  input  logic [31:0] trap_vec,
  input  logic [31:0] epc,
  input  logic [31:0] cause,
  output logic [31:0] target
);
  logic [31:0] base;
  logic [31:0] trap_pc;
  logic        unused;

  assign base = {trap_vec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign trap_pc = (trap_vec[1:0] == 2'b01 && cause[31]) ? base + {cause[29:0], 2'b00} : base;
  assign unused  = ^{epc[1:0], cause[30]};
`else
  assign trap_pc = base;
  assign unused  = ^{epc[1:0], trap_vec[1:0], cause};
`endif
  assign target = is_mret ? {epc[31:2], 2'b00} : trap_pc;
endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: serialises CSR updates one per cycle, then
// issues a one-cycle fetch redirect. Pipeline CSR writes pass through when idle.
module trap_ctrl
  import kasumi_csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  input  logic            pipe_we,
  input  logic [11:0]     pipe_waddr,
  input  logic [XLEN-1:0] pipe_wdata,
  input  logic [11:0]     pipe_raddr,
  output logic            pipe_wack,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] trap_vec,
  input  logic [XLEN-1:0] epc,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  trap_state_e state, state_nxt;
  logic [31:0] cause_q, pc_q, tval_q;
  logic        mret_q;
  logic        we_c, wack_c, redir_c;
  logic [31:0] target;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
      mret_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (trap_req) begin
          cause_q <= trap_cause;
          pc_q    <= trap_pc;
          tval_q  <= trap_tval;
          mret_q  <= 1'b0;
        end else if (mret_req) begin
          mret_q  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    we_c      = 1'b0;
    wack_c    = 1'b0;
    redir_c   = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    csr_raddr = pipe_raddr;
    case (state)
      IDLE: begin
        if (trap_req)      state_nxt = T_EPC;
        else if (mret_req) state_nxt = R_STATUS;
        else if (pipe_we) begin
          we_c      = 1'b1;
          wack_c    = 1'b1;
          csr_waddr = pipe_waddr;
          csr_wdata = pipe_wdata;
        end
      end
      T_EPC: begin
        we_c = 1'b1; csr_waddr = CSR_MEPC; csr_wdata = {pc_q[31:2], 2'b00};
        state_nxt = T_CAUSE;
      end
      T_CAUSE: begin
        we_c = 1'b1; csr_waddr = CSR_MCAUSE; csr_wdata = cause_q;
        state_nxt = T_TVAL;
      end
      T_TVAL: begin
        we_c = 1'b1; csr_waddr = CSR_MTVAL; csr_wdata = tval_q;
        state_nxt = T_STATUS;
      end
      T_STATUS: begin
        csr_raddr = CSR_MSTATUS;
        we_c = 1'b1; csr_waddr = CSR_MSTATUS; csr_wdata = trap_mstatus(csr_rdata);
        state_nxt = REDIR;
      end
      R_STATUS: begin
        csr_raddr = CSR_MSTATUS;
        we_c = 1'b1; csr_waddr = CSR_MSTATUS; csr_wdata = mret_mstatus(csr_rdata);
        state_nxt = REDIR;
      end
      REDIR: begin
        redir_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  trap_target u_target (
    .is_mret  (mret_q),
    .trap_vec (trap_vec),
    .epc      (epc),
    .cause    (cause_q),
    .target   (target)
  );

  // Reset masks every side effect in the same cycle, even mid-sequence.
  assign csr_we         = we_c & ~reset;
  assign pipe_wack      = wack_c & ~reset;
  assign busy           = (state != IDLE) & ~reset;
  assign redirect_valid = redir_c & ~reset;
  assign redirect_pc    = redirect_valid ? target : '0;
endmodule
